uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter: DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (16 at default); legal range 1..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: i_wr_data  input  8  byte to enqueue.
REQ-005 Port: i_wr_en  input  1  enqueue strobe, one byte per cycle high.
REQ-006 Port: o_full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-007 Port: o_empty  output  1  FIFO holds 0 bytes.
REQ-008 Port: o_count  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-009 Port: o_overflow  output  1  write attempted while full.
REQ-010 Port: o_tx_byte  output  8  byte to the transmitter's i_data_byte.
REQ-011 Port: o_tx_avail  output  1  one-cycle start strobe to the transmitter's i_data_avail.
REQ-012 Port: i_tx_done  input  1  transmitter's one-cycle o_done pulse.
REQ-013 Port: o_busy  output  1  high when FIFO not empty or a byte is in flight.

Function
REQ-014 The block SHALL buffer bytes in a DEPTH_LOG2-addressed circular FIFO: write and read pointers wrap from 2**DEPTH_LOG2-1 to 0.
REQ-015 A write with i_wr_en=1 and o_full=0 SHALL store i_wr_data and increment o_count at that edge.
REQ-016 A write with o_full=1 SHALL be dropped, even if a pop occurs in the same cycle; FIFO contents and o_count are unchanged.
REQ-017 A simultaneous accepted write and pop SHALL leave o_count unchanged.
REQ-018 o_full, o_empty and o_count SHALL be registered values consistent with occupancy after each edge.
REQ-019 The FSM SHALL have two states: IDLE and WAIT.
REQ-020 In IDLE with o_empty=0, at the next edge the block SHALL pop the head byte, set o_tx_byte to it, set o_tx_avail=1 and enter WAIT.
REQ-021 In IDLE with o_empty=1, the block SHALL stay in IDLE with o_tx_avail=0.
REQ-022 o_tx_avail SHALL be high for exactly one cycle per popped byte; it is cleared at the first edge in WAIT.
REQ-023 o_tx_byte SHALL hold its value from the pop until the next pop.
REQ-024 In WAIT, i_tx_done=1 SHALL return the FSM to IDLE at that edge; otherwise the FSM stays in WAIT indefinitely.
REQ-025 An i_tx_done pulse received in IDLE SHALL be ignored.
REQ-026 Latency: a write at edge N into an empty FIFO with the FSM in IDLE SHALL produce o_tx_avail=1 after edge N+1.
REQ-027 After i_tx_done at edge M with the FIFO non-empty, the next o_tx_avail SHALL be high after edge M+1.
REQ-028 Bytes SHALL be issued in write order with no loss or duplication, except for writes dropped under REQ-016.
REQ-029 o_busy SHALL equal (state==WAIT) OR (o_empty==0).

Reset
REQ-030 Asserting rst SHALL immediately clear both pointers, set o_count=0, o_empty=1, o_full=0, o_tx_avail=0, o_tx_byte=8'h00, o_overflow=0, o_busy=0, and the FSM to IDLE.
REQ-031 Reset mid-transfer SHALL discard all buffered bytes; an i_tx_done arriving after reset release SHALL be ignored under REQ-025.
REQ-032 The first pop after reset release SHALL occur no earlier than the second edge after release.

Configuration
REQ-033 When macro UART_TX_FEEDER_OVF_STICKY_EN is defined, o_overflow SHALL go high on the first dropped write and stay high until reset.
REQ-034 When UART_TX_FEEDER_OVF_STICKY_EN is undefined, o_overflow SHALL be high for exactly the one cycle following each dropped write.

Verification
REQ-035 Reset; write 8'hA5 at edge 1; transmitter model returns done 10 cycles later -> o_tx_avail high after edge 2 for one cycle, o_tx_byte=8'hA5, o_busy low after the done edge.
REQ-036 Write 8'h01,8'h02,8'h03 back-to-back; done after each -> three one-cycle strobes carrying 01,02,03 in order, each strobe one cycle after the preceding done.
REQ-037 DEPTH_LOG2=4, done withheld; write 18 bytes -> one byte popped, o_count=16 with o_full=1, 17th write accepted, 18th dropped; o_overflow behaves per REQ-033/REQ-034 in both builds.
REQ-038 Pointer wrap: stream 40 bytes 8'h00..8'h27 with writes interleaved with done pulses -> all 40 bytes issued in order; o_count returns to 0 with o_empty=1.
REQ-039 Assert rst in WAIT with 5 bytes queued, then pulse i_tx_done -> o_count=0, o_tx_avail stays 0, FSM stays IDLE, no byte issued.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter one byte per start/done handshake
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_wr_data     : byte to enqueue, taken when i_wr_en is high and the FIFO is not full
//   i_wr_en       : enqueue strobe
//   o_full        : FIFO holds 2**DEPTH_LOG2 bytes
//   o_empty       : FIFO holds no bytes
//   o_count       : FIFO occupancy
//   o_overflow    : a write was attempted while full
//   o_tx_byte     : byte presented to the transmitter, held until the next pop
//   o_tx_avail    : one-cycle start strobe to the transmitter
//   i_tx_done     : transmitter's one-cycle completion pulse
//   o_busy        : FIFO not empty or a byte is in flight
// Macro UART_TX_FEEDER_OVF_STICKY_EN: o_overflow latches until reset instead of pulsing per drop.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_wr_en,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_avail,
    input  logic                  i_tx_done,
    output logic                  o_busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state, state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  wr_acc, drop, pop;
    logic [CW-1:0]         count_nxt;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;

    always_comb
        state_nxt = (state == S_IDLE) ? (o_empty ? S_IDLE : S_WAIT) : (i_tx_done ? S_IDLE : S_WAIT);

    always_comb begin
        pop    = (state == S_IDLE) && !o_empty;
        o_busy = (state == S_WAIT) || !o_empty;
    end

    // Fullness is judged on the registered flag, so a write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        wr_acc    = i_wr_en && !o_full;
        drop      = i_wr_en && o_full;
        count_nxt = o_count + CW'(wr_acc) - CW'(pop);
    end

    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= i_wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_full     <= 1'b0;
            o_empty    <= 1'b1;
            o_tx_avail <= 1'b0;
            o_tx_byte  <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + DEPTH_LOG2'(wr_acc);
            rd_ptr     <= rd_ptr + DEPTH_LOG2'(pop);
            o_count    <= count_nxt;
            o_full     <= count_nxt == CW'(DEPTH);
            o_empty    <= count_nxt == '0;
            o_tx_avail <= pop;
            o_tx_byte  <= pop ? mem[rd_ptr] : o_tx_byte;
`ifdef UART_TX_FEEDER_OVF_STICKY_EN
            o_overflow <= o_overflow || drop;
`else
            o_overflow <= drop;
`endif
        end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized self-checking bench for uart_tx_feeder against a queue-based reference model
module tb_uart_tx_feeder;
    localparam int DL = 4;
    localparam int DEPTH = 16;
    localparam int VW = 14 + DL;
`ifdef UART_TX_FEEDER_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [VW-1:0] RST_VEC = {1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic          clk = 1'b0, rst = 1'b0;
    logic [7:0]    i_wr_data = 8'h00;
    logic          i_wr_en = 1'b0, i_tx_done = 1'b0;
    logic          o_full, o_empty, o_overflow, o_tx_avail, o_busy;
    logic [DL:0]   o_count;
    logic [7:0]    o_tx_byte;
    logic [VW-1:0] dut_vec;

    int n_tests = 0, n_fail = 0;
    logic [7:0] q[$], acc[$], got[$];
    bit inflight, exp_avail, exp_ovf;
    logic [7:0] exp_byte;

    uart_tx_feeder #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .i_wr_data(i_wr_data), .i_wr_en(i_wr_en),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_overflow(o_overflow),
        .o_tx_byte(o_tx_byte), .o_tx_avail(o_tx_avail), .i_tx_done(i_tx_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    assign dut_vec = {o_tx_avail, o_tx_byte, o_count, o_full, o_empty, o_overflow, o_busy};

    function automatic logic [VW-1:0] exp_vec();
        return {exp_avail, exp_byte, (DL+1)'(q.size()), q.size() == DEPTH, q.size() == 0,
                exp_ovf, inflight || q.size() != 0};
    endfunction

    task automatic model_clear();
        q.delete(); acc.delete(); got.delete();
        inflight = 0; exp_avail = 0; exp_ovf = 0; exp_byte = 8'h00;
    endtask

    // One clock: drive inputs, take the edge, advance the reference model, record DUT strobes.
    task automatic cycle(input bit we, input logic [7:0] d, input bit done);
        bit pop, drop;
        i_wr_en = we; i_wr_data = d; i_tx_done = done;
        @(posedge clk); #1;
        drop = we && q.size() == DEPTH;
        pop = !inflight && q.size() != 0;
        if (done) inflight = 0;
        exp_avail = pop;
        if (pop) begin exp_byte = q.pop_front(); inflight = 1; end
        if (we && !drop) begin q.push_back(d); acc.push_back(d); end
        exp_ovf = STICKY ? (exp_ovf || drop) : drop;
        if (o_tx_avail) got.push_back(o_tx_byte);
        i_wr_en = 0; i_tx_done = 0;
    endtask

    task automatic reset_on();
        #1 rst = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic reset_off();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_on();
        n_tests++;
        if (dut_vec !== RST_VEC) begin n_fail++; $display("FAIL reset_values: got %h need %h", dut_vec, RST_VEC); end
        reset_off();
        cycle(0, 8'h00, 1);
        n_tests++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_idle_done: got %h need %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_single();
        cycle(1, 8'hA5, 0);
        n_tests++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL single_write: got %h need %h", dut_vec, exp_vec()); end
        cycle(0, 8'h00, 0);
        n_tests++;
        if (o_tx_avail !== 1'b1 || o_tx_byte !== 8'hA5) begin
            n_fail++; $display("FAIL single_strobe: avail %b byte %h need 1 a5", o_tx_avail, o_tx_byte);
        end
        for (int i = 0; i < 9; i++) begin
            cycle(0, 8'h00, 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL single_wait %0d: got %h need %h", i, dut_vec, exp_vec()); end
        end
        cycle(0, 8'h00, 1);
        n_tests++;
        if (o_busy !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL single_done: busy %b vec %h need 0 %h", o_busy, dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int since;
        bit dn;
        since = -1;
        got.delete(); acc.delete();
        for (int i = 0; i < 40; i++) begin
            dn = since == 3;
            cycle(i < 3, 8'(i + 1), dn);
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL b2b cyc %0d: got %h need %h", i, dut_vec, exp_vec()); end
            since = o_tx_avail ? 0 : (since >= 0 && !dn) ? since + 1 : -1;
        end
        n_tests++;
        if (got.size() != 3 || {got[0], got[1], got[2]} !== 24'h010203) begin
            n_fail++; $display("FAIL b2b_order: got %0d bytes need 3 bytes 010203", got.size());
        end
    endtask

    task automatic test_overflow();
        int c;
        got.delete(); acc.delete();
        for (int i = 0; i < 18; i++) begin
            cycle(1, 8'($urandom), 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ovf_fill %0d: got %h need %h", i, dut_vec, exp_vec()); end
        end
        n_tests++;
        if (o_count !== 5'd16 || o_full !== 1'b1 || o_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_full: count %0d full %b ovf %b need 16 1 1", o_count, o_full, o_overflow);
        end
        cycle(0, 8'h00, 0);
        n_tests++;
        if (o_overflow !== STICKY) begin n_fail++; $display("FAIL ovf_after: got %b need %b", o_overflow, STICKY); end
        c = 0;
        while ((q.size() != 0 || inflight) && c < 400) begin
            cycle(0, 8'h00, inflight && $urandom_range(0, 1) == 1);
            c++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ovf_drain %0d: got %h need %h", c, dut_vec, exp_vec()); end
        end
        n_tests++;
        if (c >= 400 || got != acc) begin n_fail++; $display("FAIL ovf_stream: issued %0d need %0d bytes", got.size(), acc.size()); end
    endtask

    task automatic test_wrap();
        int nxt, c;
        bit we;
        nxt = 0; c = 0;
        got.delete(); acc.delete();
        while ((nxt < 40 || q.size() != 0 || inflight) && c < 2000) begin
            we = nxt < 40 && q.size() < DEPTH && $urandom_range(0, 1) == 1;
            cycle(we, 8'(nxt), inflight && $urandom_range(0, 2) == 0);
            if (we) nxt++;
            c++;
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL wrap cyc %0d: got %h need %h", c, dut_vec, exp_vec()); end
        end
        n_tests++;
        if (c >= 2000 || o_count !== '0 || o_empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_end: cycles %0d count %0d empty %b need 0 1", c, o_count, o_empty);
        end
        for (int i = 0; i < 40; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== 8'(i)) begin
                n_fail++; $display("FAIL wrap_byte %0d: got %h need %h", i, i < got.size() ? got[i] : 8'hxx, 8'(i));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %h need %h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_reset_midxfer();
        reset_on();
        reset_off();
        for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), 0);
        n_tests++;
        if (o_count !== 5'd5 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: count %0d busy %b need 5 1", o_count, o_busy);
        end
        reset_on();
        n_tests++;
        if (dut_vec !== RST_VEC) begin n_fail++; $display("FAIL mid_reset: got %h need %h", dut_vec, RST_VEC); end
        reset_off();
        cycle(0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (dut_vec !== RST_VEC) begin n_fail++; $display("FAIL mid_after %0d: got %h need %h", i, dut_vec, RST_VEC); end
            cycle(0, 8'h00, 0);
        end
        n_tests++;
        if (got.size() != 0) begin n_fail++; $display("FAIL mid_issued: got %0d bytes need 0", got.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_random();
        test_reset_midxfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end
endmodule
